vend_change_ctrl: RTL and testbench
===================================

// Module: vend_change_ctrl
// PURPOSE
//  Sequencing controller for the vending datapath. Accepts one-cycle coin pulses
//  (nickel/dime/quarter) and accumulates credit. Issues a one-cycle dispense pulse
//  once credit reaches PRICE. Then drives the change hopper with a req/ack
//  handshake to return the remainder as dimes first, then nickels.
//  Sits between the coin acceptor front-end and the dispenser/hopper actuators.
// PARAMETERS
//  PRICE        25    product price in cents; multiple of 5; 5..MAX_CREDIT
//  MAX_CREDIT   95    maximum credit held in cents; multiple of 5
//  CREDIT_W     7     credit register width; must hold MAX_CREDIT
//  HOP_TIMEOUT  1000  cycles allowed from hop_req rise to hop_ack before FAULT
// PORTS
//  clock     in   1         system clock, rising edge
//  reset_n   in   1         synchronous, active-low reset
//  N         in   1         nickel pulse (5c), one cycle per coin
//  D         in   1         dime pulse (10c), one cycle per coin
//  Q         in   1         quarter pulse (25c), one cycle per coin
//  cancel    in   1         refund request, one-cycle pulse
//  hop_ack   in   1         hopper ejected the requested coin; one-cycle pulse
//  P         out  1         dispense product; one-cycle pulse
//  coin_rej  out  1         last-cycle coin refused; one-cycle pulse
//  hop_req   out  1         hopper eject request; level
//  hop_coin  out  1         coin to eject: 1 = dime, 0 = nickel; valid while hop_req
//  credit    out  CREDIT_W  current credit in cents
//  busy      out  1         high in any state other than COLLECT
//  fault     out  1         hopper timeout; sticky until reset
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=COLLECT; credit, P, coin_rej, hop_req,
//   hop_coin, fault and timeout counter all go to 0. Credit held at reset is
//   discarded; no refund is made.
//  All outputs are registered (Moore). Effects appear in the cycle after the
//   sampling edge.
//  States: COLLECT, VEND, CHANGE, CHG_GAP, FAULT.
//  COLLECT:
//   - Exactly one of N/D/Q high, and credit+value <= MAX_CREDIT: credit += value.
//     The sum is computed at CREDIT_W+1 bits.
//   - If the new credit >= PRICE, go to VEND.
//   - Coin refused (coin_rej=1 next cycle, credit unchanged) when:
//     >1 of N/D/Q high in one cycle, or credit+value > MAX_CREDIT.
//   - cancel with credit>0: go to CHANGE (refund). cancel with credit==0: ignored.
//   - cancel together with a coin: cancel wins; the coin is refused.
//  VEND (exactly 1 cycle):
//   - P=1; credit shows the pre-deduction value.
//   - On exit, credit -= PRICE.
//   - Next state is CHANGE if the remainder > 0, else COLLECT.
//  CHANGE:
//   - hop_req=1; hop_coin=(credit>=10).
//   - Both outputs are held stable until hop_ack is sampled high.
//   - On ack: credit -= 10 or 5 (per hop_coin); go to CHG_GAP.
//  CHG_GAP (1 cycle): hop_req=0. Next state is CHANGE if credit>0, else COLLECT.
//   Guarantees hop_req is low for at least one cycle between ejects.
//  Timeout:
//   - Counter clears on entry to CHANGE.
//   - Counter increments each CHANGE cycle without ack.
//   - On reaching HOP_TIMEOUT: go to FAULT.
//  FAULT: hop_req=0, fault=1, credit frozen. All coins refused; cancel ignored.
//   Exit only via reset.
//  In VEND/CHANGE/CHG_GAP/FAULT: any coin is refused (coin_rej=1); cancel is ignored.
//  hop_ack while hop_req=0 is ignored.
//  hop_ack arriving in the same cycle as the timeout: the ack wins.
//  Credit never underflows: credit is always a multiple of 5, and change logic
//   subtracts 10 only when credit >= 10.
// TESTING
//  1. Q at reset defaults -> credit 25, VEND with P=1 for one cycle, then
//     COLLECT, credit 0, no hop_req.
//  2. D,D,D on separate cycles -> credit 10,20,30; P pulse; CHANGE with
//     hop_coin=0, credit 5; hop_ack -> credit 0, back to COLLECT.
//  3. N, then cancel -> CHANGE with hop_coin=0; ack -> credit 0, P never asserted.
//  4. With PRICE=95: Q,Q,Q,D,N -> credit 85, then 90 (N accepted).
//     N/D/Q below PRICE are accumulated; Q at 90 -> coin_rej, credit stays 90.
//  5. D and Q high in the same cycle -> coin_rej=1, credit unchanged.
//     Coin during CHANGE -> coin_rej=1.
//  6. Enter CHANGE and withhold hop_ack for HOP_TIMEOUT cycles -> fault=1,
//     hop_req=0, sticky.
//     Separately: reset_n=0 mid-CHANGE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/vend_change_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_change_ctrl
// Purpose  : Coin credit accumulator, dispense pulse and dime/nickel change
//            hopper sequencer with req/ack handshake and eject timeout.
// Revision : 1.0  initial release
// ============================================================================
module vend_change_ctrl #(
    parameter int PRICE       = 25,
    parameter int MAX_CREDIT  = 95,
    parameter int CREDIT_W    = 7,
    parameter int HOP_TIMEOUT = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                cancel,
    input  logic                hop_ack,
    output logic                P,
    output logic                coin_rej,
    output logic                hop_req,
    output logic                hop_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                fault
);

    localparam int c_TMO_W = $clog2(HOP_TIMEOUT + 1);

    localparam logic [2:0] c_S_COLLECT = 3'd0;
    localparam logic [2:0] c_S_VEND    = 3'd1;
    localparam logic [2:0] c_S_CHANGE  = 3'd2;
    localparam logic [2:0] c_S_CHG_GAP = 3'd3;
    localparam logic [2:0] c_S_FAULT   = 3'd4;

    localparam logic [CREDIT_W:0]   c_V5       = (CREDIT_W+1)'(5);
    localparam logic [CREDIT_W:0]   c_V10      = (CREDIT_W+1)'(10);
    localparam logic [CREDIT_W:0]   c_V25      = (CREDIT_W+1)'(25);
    localparam logic [CREDIT_W:0]   c_MAX_X    = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   c_PRICE_X  = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] c_PRICE    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] c_FIVE     = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] c_TEN      = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] c_ZERO     = '0;
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(HOP_TIMEOUT - 1);

    logic [2:0]          r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [c_TMO_W-1:0]  r_tmo, w_tmo_nxt;
    logic                r_coin_rej, w_coin_rej_nxt;

    logic [1:0]          w_coin_cnt;
    logic                w_coin_any;
    logic [CREDIT_W:0]   w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic                w_dime;
    logic [CREDIT_W-1:0] w_after_vend;

    assign w_coin_cnt   = {1'b0, N} + {1'b0, D} + {1'b0, Q};
    assign w_coin_any   = N | D | Q;
    assign w_coin_val   = N ? c_V5 : (D ? c_V10 : (Q ? c_V25 : '0));
    assign w_sum        = {1'b0, r_credit} + w_coin_val;
    assign w_dime       = (r_credit >= c_TEN);
    assign w_after_vend = r_credit - c_PRICE;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= c_S_COLLECT;
            r_credit   <= '0;
            r_tmo      <= '0;
            r_coin_rej <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_tmo      <= w_tmo_nxt;
            r_coin_rej <= w_coin_rej_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_tmo_nxt      = '0;
        w_coin_rej_nxt = w_coin_any;
        case (r_state)
            c_S_COLLECT: begin
                // An effective cancel takes priority over any coin in the same cycle
                if (cancel && (r_credit != c_ZERO)) begin
                    w_state_nxt = c_S_CHANGE;
                end else if (w_coin_any) begin
                    if ((w_coin_cnt > 2'd1) || (w_sum > c_MAX_X)) begin
                        w_coin_rej_nxt = 1'b1;
                    end else begin
                        w_coin_rej_nxt = 1'b0;
                        w_credit_nxt   = w_sum[CREDIT_W-1:0];
                        if (w_sum >= c_PRICE_X) begin
                            w_state_nxt = c_S_VEND;
                        end
                    end
                end
            end
            c_S_VEND: begin
                w_credit_nxt = w_after_vend;
                w_state_nxt  = (w_after_vend != c_ZERO) ? c_S_CHANGE : c_S_COLLECT;
            end
            c_S_CHANGE: begin
                // An ack landing on the final timeout cycle still completes the eject
                if (hop_ack) begin
                    w_credit_nxt = r_credit - (w_dime ? c_TEN : c_FIVE);
                    w_state_nxt  = c_S_CHG_GAP;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_nxt = c_S_FAULT;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            c_S_CHG_GAP: begin
                w_state_nxt = (r_credit != c_ZERO) ? c_S_CHANGE : c_S_COLLECT;
            end
            c_S_FAULT: begin
                w_state_nxt = c_S_FAULT;
            end
            default: begin
                w_state_nxt  = c_S_COLLECT;
                w_credit_nxt = '0;
            end
        endcase
    end

    always_comb begin
        P        = (r_state == c_S_VEND);
        hop_req  = (r_state == c_S_CHANGE);
        hop_coin = (r_state == c_S_CHANGE) && w_dime;
        busy     = (r_state != c_S_COLLECT);
        fault    = (r_state == c_S_FAULT);
        credit   = r_credit;
        coin_rej = r_coin_rej;
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_change_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_change_ctrl
// Purpose  : Directed vector table plus hand sequences for vend_change_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_vend_change_ctrl;

    localparam int c_T = 20;

    logic clk = 1'b0;
    logic reset_n, n_s, d_s, q_s, cancel_s, ack_s;

    logic       a_p, a_rej, a_req, a_coin, a_busy, a_fault;
    logic [6:0] a_credit;
    logic       b_p, b_rej, b_req, b_coin, b_busy, b_fault;
    logic [6:0] b_credit;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vend_change_ctrl #(.PRICE(25), .MAX_CREDIT(95), .CREDIT_W(7), .HOP_TIMEOUT(c_T)) dut_a (
        .clock(clk), .reset_n(reset_n), .N(n_s), .D(d_s), .Q(q_s), .cancel(cancel_s),
        .hop_ack(ack_s), .P(a_p), .coin_rej(a_rej), .hop_req(a_req), .hop_coin(a_coin),
        .credit(a_credit), .busy(a_busy), .fault(a_fault)
    );

    vend_change_ctrl #(.PRICE(95), .MAX_CREDIT(95), .CREDIT_W(7), .HOP_TIMEOUT(c_T)) dut_b (
        .clock(clk), .reset_n(reset_n), .N(n_s), .D(d_s), .Q(q_s), .cancel(cancel_s),
        .hop_ack(ack_s), .P(b_p), .coin_rej(b_rej), .hop_req(b_req), .hop_coin(b_coin),
        .credit(b_credit), .busy(b_busy), .fault(b_fault)
    );

    // in = {N, D, Q, cancel, hop_ack}; exp = {P, coin_rej, hop_req, hop_coin, credit, busy, fault}
    typedef struct packed {
        logic        rst_n;
        logic        sel;
        logic [4:0]  in;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    localparam logic [4:0] I0 = 5'b00000, IN = 5'b10000, ID = 5'b01000, IQ = 5'b00100;
    localparam logic [4:0] IC = 5'b00010, IA = 5'b00001, IDQ = 5'b01100;
    localparam logic [4:0] IDAC = 5'b01011;

    function automatic logic [12:0] ex(input logic p, input logic r, input logic rq,
                                       input logic cn, input int cr, input logic b, input logic f);
        logic [6:0] c;
        c = 7'(cr);
        return {p, r, rq, cn, c, b, f};
    endfunction

    task automatic add(input logic rst, input logic sel, input logic [4:0] in, input logic [12:0] e);
        vec_t v;
        v.rst_n = rst; v.sel = sel; v.in = in; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic step(input logic rst, input logic [4:0] in);
        reset_n = rst;
        {n_s, d_s, q_s, cancel_s, ack_s} = in;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        {n_s, d_s, q_s, cancel_s, ack_s} = '0;
    endtask

    task automatic chk(input string name, input logic sel, input logic [12:0] e);
        logic [12:0] act;
        act = sel ? {b_p, b_rej, b_req, b_coin, b_credit, b_busy, b_fault}
                  : {a_p, a_rej, a_req, a_coin, a_credit, a_busy, a_fault};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got P=%b rej=%b req=%b coin=%b credit=%0d busy=%b fault=%b, want P=%b rej=%b req=%b coin=%b credit=%0d busy=%b fault=%b",
                     name, act[12], act[11], act[10], act[9], act[8:2], act[1], act[0],
                     e[12], e[11], e[10], e[9], e[8:2], e[1], e[0]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {n_s, d_s, q_s, cancel_s, ack_s} = '0;

        // PRICE=25 unit: vend, change, refund, rejects
        add(0, 0, I0,  ex(0,0,0,0, 0,0,0));
        add(1, 0, IQ,  ex(1,0,0,0,25,1,0));
        add(1, 0, I0,  ex(0,0,0,0, 0,0,0));
        add(1, 0, ID,  ex(0,0,0,0,10,0,0));
        add(1, 0, ID,  ex(0,0,0,0,20,0,0));
        add(1, 0, ID,  ex(1,0,0,0,30,1,0));
        add(1, 0, I0,  ex(0,0,1,0, 5,1,0));
        add(1, 0, I0,  ex(0,0,1,0, 5,1,0));
        add(1, 0, IA,  ex(0,0,0,0, 0,1,0));
        add(1, 0, I0,  ex(0,0,0,0, 0,0,0));
        add(1, 0, IN,  ex(0,0,0,0, 5,0,0));
        add(1, 0, IC,  ex(0,0,1,0, 5,1,0));
        add(1, 0, IN,  ex(0,1,1,0, 5,1,0));
        add(1, 0, IA,  ex(0,0,0,0, 0,1,0));
        add(1, 0, I0,  ex(0,0,0,0, 0,0,0));
        add(1, 0, IA,  ex(0,0,0,0, 0,0,0));
        add(1, 0, IC,  ex(0,0,0,0, 0,0,0));
        add(1, 0, IDQ, ex(0,1,0,0, 0,0,0));
        add(1, 0, ID,  ex(0,0,0,0,10,0,0));
        add(1, 0, IC,  ex(0,0,1,1,10,1,0));
        add(1, 0, IA,  ex(0,0,0,0, 0,1,0));
        add(1, 0, I0,  ex(0,0,0,0, 0,0,0));
        add(1, 0, ID,  ex(0,0,0,0,10,0,0));
        add(1, 0, ID,  ex(0,0,0,0,20,0,0));
        add(1, 0, IQ,  ex(1,0,0,0,45,1,0));
        add(1, 0, I0,  ex(0,0,1,1,20,1,0));
        add(1, 0, IA,  ex(0,0,0,0,10,1,0));
        add(1, 0, I0,  ex(0,0,1,1,10,1,0));
        add(1, 0, IA,  ex(0,0,0,0, 0,1,0));
        add(1, 0, I0,  ex(0,0,0,0, 0,0,0));
        // PRICE=95 unit: accumulate to the ceiling, overflow rejects
        add(0, 1, I0,  ex(0,0,0,0, 0,0,0));
        add(1, 1, IQ,  ex(0,0,0,0,25,0,0));
        add(1, 1, IQ,  ex(0,0,0,0,50,0,0));
        add(1, 1, IQ,  ex(0,0,0,0,75,0,0));
        add(1, 1, ID,  ex(0,0,0,0,85,0,0));
        add(1, 1, IN,  ex(0,0,0,0,90,0,0));
        add(1, 1, IQ,  ex(0,1,0,0,90,0,0));
        add(1, 1, ID,  ex(0,1,0,0,90,0,0));
        add(1, 1, IN,  ex(1,0,0,0,95,1,0));
        add(1, 1, ID,  ex(0,1,0,0, 0,0,0));
        add(1, 1, I0,  ex(0,0,0,0, 0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].in);
            chk($sformatf("vec%0d", i), tbl[i].sel, tbl[i].exp);
        end

        // Ack on the last allowed cycle beats the timeout
        step(0, I0);
        step(1, IN);
        step(1, IC);
        repeat (c_T - 1) step(1, I0);
        chk("pre_timeout_wait", 0, ex(0,0,1,0,5,1,0));
        step(1, IA);
        chk("ack_wins_timeout", 0, ex(0,0,0,0,0,1,0));
        step(1, I0);
        chk("ack_wins_collect", 0, ex(0,0,0,0,0,0,0));

        // Withheld ack escalates to a sticky fault
        step(1, IN);
        step(1, IC);
        repeat (c_T - 1) step(1, I0);
        chk("timeout_edge_minus1", 0, ex(0,0,1,0,5,1,0));
        step(1, I0);
        chk("timeout_fault", 0, ex(0,0,0,0,5,1,1));
        step(1, IDAC);
        chk("fault_rej_coin", 0, ex(0,1,0,0,5,1,1));
        repeat (3) step(1, IC);
        chk("fault_sticky", 0, ex(0,0,0,0,5,1,1));
        step(0, I0);
        chk("fault_cleared_by_reset", 0, ex(0,0,0,0,0,0,0));

        // Reset in the middle of a change eject
        step(1, ID);
        step(1, IC);
        chk("mid_change", 0, ex(0,0,1,1,10,1,0));
        step(0, IN);
        chk("reset_mid_change", 0, ex(0,0,0,0,0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
